tape_unit: RTL and testbench

- Sequential tape store and head for the universal Turing machine datapath.
- Sits directly downstream of the new-symbol/next-move logic. Each accepted step writes the 3-bit new symbol into the cell under the head, moves the head, then presents the symbol under the new head position as the current symbol.
- The current-symbol output feeds back into the combinational transition logic on the next step.

---
 rtl/tape_unit_if.sv | 36 +++
 rtl/tape_unit.sv | 169 ++++++++++++++++
 tb/tb_tape_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_unit_if.sv
// -----------------------------------------------------------------------------
// tape_unit_if
// Step/load/status bundle between the transition logic (master) and the tape
// store and head (slave).
//   step_valid/step_ready : one tape step request, accepted when both high
//   new_sym, move         : symbol to write under the head and head motion
//   load_en/addr/data     : direct tape write used for initialisation
//   cur_sym, cur_valid    : registered symbol under the head and its validity
//   head_pos              : current head address
//   edge_err              : sticky "move tried to leave the tape" flag
// -----------------------------------------------------------------------------
interface tape_unit_if #(
  parameter int ADDR_W = 4
);
  logic              step_valid;
  logic              step_ready;
  logic [2:0]        new_sym;
  logic [1:0]        move;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [2:0]        load_data;
  logic [2:0]        cur_sym;
  logic              cur_valid;
  logic [ADDR_W-1:0] head_pos;
  logic              edge_err;

  modport master (
    output step_valid, new_sym, move, load_en, load_addr, load_data,
    input  step_ready, cur_sym, cur_valid, head_pos, edge_err
  );

  modport slave (
    input  step_valid, new_sym, move, load_en, load_addr, load_data,
    output step_ready, cur_sym, cur_valid, head_pos, edge_err
  );
endinterface

// File: rtl/tape_unit.sv
// -----------------------------------------------------------------------------
// tape_unit
// Sequential tape store and head for the universal Turing machine datapath.
// Each accepted step writes new_sym into the cell under the head, moves the
// head, then presents the symbol under the new head as cur_sym, which feeds
// back into the transition logic for the next step.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   tu     : tape_unit_if.slave (step handshake, load port, status outputs)
//
// Parameters: DEPTH (power of two, >= 4), ADDR_W = log2(DEPTH), INIT_HEAD.
//
// Build option: define TAPE_WRAP_EN for a circular tape (head wraps modulo
// DEPTH, FAULT unreachable, edge_err tied low). Default build faults on an
// attempt to move off either end.
// -----------------------------------------------------------------------------
module tape_unit #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int INIT_HEAD = 8
) (
  input  logic        clk,
  input  logic        reset,
  tape_unit_if.slave  tu
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] INIT_ADDR = ADDR_W'(INIT_HEAD);

  typedef enum logic [2:0] {
    READY = 3'd0,
    WRITE = 3'd1,
    MOVE  = 3'd2,
    FETCH = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [2:0]        cells [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] head_nxt;
  logic [2:0]        sym_q;
  logic [1:0]        move_q;
  logic [2:0]        cur_sym_q;
  logic              cur_valid_q;
  logic              edge_err_q;

  logic              step_ready;
  logic              accept;
  logic              load_hit;
  logic              go_right;
  logic              go_left;
  logic              off_edge;

  // Decode of the captured move; 2'b11 falls through as "stay".
  assign go_right = (move_q == 2'b01);
  assign go_left  = (move_q == 2'b10);

  // ADDR_W-bit arithmetic wraps modulo DEPTH on its own; in the default build
  // off_edge routes to FAULT before the head register is ever updated, so the
  // wrapped value is never committed.
  always_comb begin
    head_nxt = head;
    if (go_right)     head_nxt = head + ADDR_W'(1);
    else if (go_left) head_nxt = head - ADDR_W'(1);
  end

`ifdef TAPE_WRAP_EN
  assign off_edge = 1'b0;
`else
  assign off_edge = (go_left && (head == '0)) || (go_right && (head == LAST_ADDR));
`endif

  // Load only lands in READY; step_ready is masked by load_en so a
  // simultaneous step is never accepted.
  assign load_hit = (state == READY) && tu.load_en;
  assign accept   = tu.step_valid && step_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= READY;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: defaulting state_nxt before the case keeps every path assigned, so
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (accept) state_nxt = WRITE;
      WRITE:   state_nxt = off_edge ? FAULT : MOVE;
      MOVE:    state_nxt = FETCH;
      FETCH:   state_nxt = READY;
      FAULT:   state_nxt = FAULT;   // exits only through reset
      default: state_nxt = READY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    step_ready = (state == READY) && !tu.load_en && !edge_err_q;
  end

  assign tu.step_ready = step_ready;
  assign tu.cur_sym    = cur_sym_q;
  assign tu.cur_valid  = cur_valid_q;
  assign tu.head_pos   = head;
`ifdef TAPE_WRAP_EN
  assign tu.edge_err   = 1'b0;
`else
  assign tu.edge_err   = edge_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: tape cells, head, captured step, current symbol, error flag
  // ---------------------------------------------------------------------------
  // NOTE: the tape array is built from resettable flops rather than RAM,
  // because reset must return every cell to blank and abort any in-flight
  // write without leaving a partial result behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= 3'b000;
      head        <= INIT_ADDR;
      sym_q       <= 3'b000;
      move_q      <= 2'b00;
      cur_sym_q   <= 3'b000;
      cur_valid_q <= 1'b1;
      edge_err_q  <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (load_hit) begin
            cells[tu.load_addr] <= tu.load_data;
            // Keep cur_sym coherent when initialising the cell under the head.
            if (tu.load_addr == head) cur_sym_q <= tu.load_data;
          end else if (accept) begin
            sym_q       <= tu.new_sym;
            move_q      <= tu.move;
            cur_valid_q <= 1'b0;
          end
        end
        WRITE: begin
          cells[head] <= sym_q;
          if (off_edge) edge_err_q <= 1'b1;
        end
        MOVE:  head <= head_nxt;
        FETCH: begin
          cur_sym_q   <= cells[head];
          cur_valid_q <= 1'b1;
        end
        default: ;  // FAULT: hold everything until reset
      endcase
    end
  end

endmodule

// File: tb/tb_tape_unit.sv
// -----------------------------------------------------------------------------
// tb_tape_unit
// Randomised scoreboard bench for tape_unit. dut_a (INIT_HEAD = 8) carries the
// directed and random traffic; dut_b (INIT_HEAD = 0) exercises the left-edge
// move. A tape/head reference model pushes the expected symbol, head and
// completion cycle of every accepted step; a monitor pops on each cur_valid
// rise. Honours TAPE_WRAP_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_tape_unit;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clk = ~clk;

  tape_unit_if #(.ADDR_W(AW)) ifa ();
  tape_unit_if #(.ADDR_W(AW)) ifb ();

  tape_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .INIT_HEAD(8)) dut_a (
    .clk(clk), .reset(reset_a), .tu(ifa)
  );
  tape_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .INIT_HEAD(0)) dut_b (
    .clk(clk), .reset(reset_b), .tu(ifb)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sym;
    int head;
    int cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: the tape as a plain array and the head as an integer.
  int model_cells[DEPTH];
  int model_head;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    foreach (model_cells[i]) model_cells[i] = 0;
    model_head = 8;
    sb.delete();
  endtask

  // Apply one accepted step to the model; queue the expected fetch result.
  task automatic model_step(input int sym, input int mv, input int acc_cyc, output bit fault);
    int delta;
    int target;
    model_cells[model_head] = sym;
    delta  = (mv == 1) ? 1 : ((mv == 2) ? -1 : 0);
    target = model_head + delta;
`ifdef TAPE_WRAP_EN
    target = (target + DEPTH) % DEPTH;
    fault  = 1'b0;
`else
    fault  = (target < 0) || (target >= DEPTH);
`endif
    if (!fault) begin
      model_head = target;
      sb.push_back('{sym: model_cells[target], head: target, cyc: acc_cyc + 3});
    end
  endtask

  // Monitor: every cur_valid rise on dut_a must match the oldest expectation.
  logic prev_valid = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (reset_a) begin
      prev_valid <= 1'b1;
    end else begin
      if (ifa.cur_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_cur_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("step_sym", int'(ifa.cur_sym), e.sym);
          check("step_head", int'(ifa.head_pos), e.head);
          check("step_latency", cyc, e.cyc);
        end
      end
      prev_valid <= ifa.cur_valid;
    end
  end

  // Called at a negedge; waits (bounded) for step_ready.
  task automatic wait_ready_a(output bit ok);
    int n = 0;
    while (!ifa.step_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = ifa.step_ready;
    if (!ok) check("step_ready_timeout", 0, 1);
  endtask

  // Issue one step to dut_a; returns at the negedge after acceptance (WRITE).
  task automatic do_step_a(input int sym, input int mv, output bit fault);
    bit ok;
    fault = 1'b0;
    wait_ready_a(ok);
    if (!ok) return;
    ifa.new_sym    = 3'(sym);
    ifa.move       = 2'(mv);
    ifa.step_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.step_valid = 1'b0;
    // Inputs are captured at acceptance, so scramble them immediately.
    ifa.new_sym    = 3'($urandom);
    ifa.move       = 2'($urandom);
    model_step(sym, mv, cyc, fault);
    @(negedge clk);
  endtask

  // Load into dut_a while it is in READY; model updated alongside.
  task automatic do_load_a(input int addr, input int data);
    bit ok;
    wait_ready_a(ok);
    if (!ok) return;
    ifa.load_en   = 1'b1;
    ifa.load_addr = AW'(addr);
    ifa.load_data = 3'(data);
    @(posedge clk);
    #1;
    ifa.load_en   = 1'b0;
    model_cells[addr] = data;
    @(negedge clk);
    if (addr == model_head) check("load_cur_sym", int'(ifa.cur_sym), data);
  endtask

  task automatic pulse_reset_a();
    reset_a = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit fault;
    bit ok;
    int data;
    int ready_seen;

    ifa.step_valid = 1'b0; ifa.new_sym = '0; ifa.move = '0;
    ifa.load_en = 1'b0; ifa.load_addr = '0; ifa.load_data = '0;
    ifb.step_valid = 1'b0; ifb.new_sym = '0; ifb.move = '0;
    ifb.load_en = 1'b0; ifb.load_addr = '0; ifb.load_data = '0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);

    // Reset / idle state.
    check("rst_head", int'(ifa.head_pos), 8);
    check("rst_cur_sym", int'(ifa.cur_sym), 0);
    check("rst_cur_valid", int'(ifa.cur_valid), 1);
    check("rst_step_ready", int'(ifa.step_ready), 1);
    check("rst_edge_err", int'(ifa.edge_err), 0);

    // Make cell 9 non-blank, then abort a step (sym 5) with reset mid-WRITE.
    do_load_a(9, 6);
    ifa.new_sym = 3'd5; ifa.move = 2'b00; ifa.step_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.step_valid = 1'b0;
    reset_a = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    check("abort_head", int'(ifa.head_pos), 8);
    check("abort_cur_sym", int'(ifa.cur_sym), 0);
    check("abort_cur_valid", int'(ifa.cur_valid), 1);
    // Right then left: cell 9 must be blank again, cell 8 holds our write.
    do_step_a(2, 1, fault);
    do_step_a(1, 2, fault);

    // Load cell 9 = 6, step right writing 3, then step back left.
    do_load_a(9, 6);
    do_step_a(3, 1, fault);
    do_step_a(0, 2, fault);

    // Stay moves: 00 and 11.
    do_step_a(4, 0, fault);
    do_step_a(5, 3, fault);

    // Load and step together in READY: load wins, step is not accepted.
    wait_ready_a(ok);
    ifa.load_en = 1'b1; ifa.load_addr = AW'(model_head); ifa.load_data = 3'd7;
    ifa.new_sym = 3'd1; ifa.move = 2'b01; ifa.step_valid = 1'b1;
    #1;
    check("load_blocks_ready", int'(ifa.step_ready), 0);
    @(posedge clk);
    #1;
    ifa.step_valid = 1'b0;
    ifa.load_en    = 1'b0;
    model_cells[model_head] = 7;
    @(negedge clk);
    check("load_step_cur_sym", int'(ifa.cur_sym), 7);
    repeat (4) @(negedge clk);
    check("load_step_no_accept_valid", int'(ifa.cur_valid), 1);
    check("load_step_no_accept_head", int'(ifa.head_pos), model_head);

    // Loads during WRITE/MOVE/FETCH are ignored, even at the cell being fetched.
    do_step_a(2, 1, fault);
    data = (model_cells[model_head] + 1) % 8;
    ifa.load_en = 1'b1; ifa.load_addr = AW'(model_head); ifa.load_data = 3'(data);
    repeat (3) @(posedge clk);
    #1;
    ifa.load_en = 1'b0;
    @(negedge clk);

    // Random traffic against the model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load_a(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)));
      end else begin
        do_step_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), fault);
        if (fault) begin
          repeat (3) @(negedge clk);
          check("rnd_fault_edge_err", int'(ifa.edge_err), 1);
          check("rnd_fault_ready", int'(ifa.step_ready), 0);
          check("rnd_fault_valid", int'(ifa.cur_valid), 0);
          check("rnd_fault_head", int'(ifa.head_pos), model_head);
          pulse_reset_a();
        end
      end
    end

    // Left-edge move on dut_b (head starts at 0), writing 7.
    ifb.new_sym = 3'd7; ifb.move = 2'b10; ifb.step_valid = 1'b1;
    @(posedge clk);
    #1;
    ifb.step_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef TAPE_WRAP_EN
    check("wrap_head", int'(ifb.head_pos), DEPTH - 1);
    check("wrap_edge_err", int'(ifb.edge_err), 0);
    check("wrap_cur_valid", int'(ifb.cur_valid), 1);
    check("wrap_cur_sym", int'(ifb.cur_sym), 0);
`else
    check("edge_err_set", int'(ifb.edge_err), 1);
    check("edge_head", int'(ifb.head_pos), 0);
    check("edge_cur_valid", int'(ifb.cur_valid), 0);
    check("edge_cell0", int'(dut_b.cells[0]), 7);
    ready_seen = 0;
    ifb.step_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifb.step_ready) ready_seen++;
    end
    ifb.step_valid = 1'b0;
    check("edge_ready_held_low", ready_seen, 0);
    check("edge_err_sticky", int'(ifb.edge_err), 1);
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("edge_reset_clears", int'(ifb.edge_err), 0);
    check("edge_reset_ready", int'(ifb.step_ready), 1);
`endif

    // Drain outstanding expectations (bounded).
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
